// File: rtl/mc_main_fsm_pkg.sv
// mc_pkg: state, opcode and aluop encodings plus the control-word struct for mc_main_fsm (optional addi support via MC_ADDI_EN)
package mc_pkg;
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;
endpackage

// File: rtl/mc_main_fsm_if.sv
// mc_main_fsm_if: opcode/flag inputs and datapath control outputs of the main controller
interface mc_main_fsm_if;
    logic [5:0] op;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       pcen;
    logic       illegal;
    logic [3:0] state;
    modport master (
        input  op, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, aluop, pcen, illegal, state
    );
    modport slave (
        output op, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, aluop, pcen, illegal, state
    );
endinterface

// File: rtl/mc_main_fsm_outdec.sv
// mc_outdec: Moore state-to-control-word decoder; ADDIEX/ADDIWB decode only with MC_ADDI_EN
module mc_outdec
    import mc_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);
    // one control word per state, everything unlisted stays 0
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH:   begin ctrl.alusrcb = 2'b01; ctrl.irwrite = 1'b1; ctrl.pcwrite = 1'b1; end
            DECODE:  ctrl.alusrcb = 2'b11;
            MEMADR:  begin ctrl.alusrca = 1'b1; ctrl.alusrcb = 2'b10; end
            MEMRD:   ctrl.iord = 1'b1;
            MEMWB:   begin ctrl.memtoreg = 1'b1; ctrl.regwrite = 1'b1; end
            MEMWR:   begin ctrl.iord = 1'b1; ctrl.memwrite = 1'b1; end
            RTYPEEX: begin ctrl.alusrca = 1'b1; ctrl.aluop = ALUOP_FUNCT; end
            RTYPEWB: begin ctrl.regdst = 1'b1; ctrl.regwrite = 1'b1; end
            BEQEX:   begin ctrl.alusrca = 1'b1; ctrl.aluop = ALUOP_SUB; ctrl.pcsrc = 2'b01; ctrl.branch = 1'b1; end
`ifdef MC_ADDI_EN
            ADDIEX:  begin ctrl.alusrca = 1'b1; ctrl.alusrcb = 2'b10; end
            ADDIWB:  ctrl.regwrite = 1'b1;
`endif
            JEX:     begin ctrl.pcsrc = 2'b10; ctrl.pcwrite = 1'b1; end
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/mc_main_fsm.sv
// mc_main_fsm: multi-cycle MIPS main controller FSM; MC_ADDI_EN enables the addi path
module mc_main_fsm
    import mc_pkg::*;
(
    input logic          clk,
    input logic          rst,
    mc_main_fsm_if.master bus
);
    state_t state_q, state_d;
    logic   sw_q, bad_op;
    ctrl_t  ctrl;
    mc_outdec u_outdec (.state(state_q), .ctrl(ctrl));
    // state register; lw/sw is remembered at DECODE since op is only valid there
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            sw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) sw_q <= (bus.op == OP_SW);
        end
    end
    // next-state logic; unknown opcodes and unreachable codes fall back to FETCH
    always_comb begin
        state_d = FETCH;
        bad_op  = 1'b0;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = ADDIEX;
`endif
                    OP_J:         state_d = JEX;
                    default:      bad_op  = 1'b1;
                endcase
            MEMADR:  state_d = sw_q ? MEMWR : MEMRD;
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
`ifdef MC_ADDI_EN
            ADDIEX:  state_d = ADDIWB;
`endif
            default: state_d = FETCH;
        endcase
    end
    // outputs; write enables and pulses are masked while reset is held
    always_comb begin
        bus.iord     = ctrl.iord;
        bus.memwrite = ctrl.memwrite & ~rst;
        bus.irwrite  = ctrl.irwrite & ~rst;
        bus.regdst   = ctrl.regdst;
        bus.memtoreg = ctrl.memtoreg;
        bus.regwrite = ctrl.regwrite & ~rst;
        bus.alusrca  = ctrl.alusrca;
        bus.alusrcb  = ctrl.alusrcb;
        bus.pcsrc    = ctrl.pcsrc;
        bus.aluop    = ctrl.aluop;
        bus.pcen     = (ctrl.pcwrite | (ctrl.branch & bus.zero)) & ~rst;
        bus.illegal  = bad_op & ~rst;
        bus.state    = state_q;
    end
endmodule

// File: tb/tb_mc_main_fsm.sv
// tb_mc_main_fsm: directed and random instruction streams checked against a per-instruction state/control model
module tb_mc_main_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    always #5 clk = ~clk;
    mc_main_fsm_if bus ();
    mc_main_fsm dut (.clk(clk), .rst(rst), .bus(bus));
    localparam logic [14:0] RST_VEC = {7'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic logic [14:0] exp_out(input int st, input logic z, input logic ill);
        logic iord, mw, irw, rd, mtr, rw, asa, pw, br;
        logic [1:0] asb, pcs, aop;
        {iord, mw, irw, rd, mtr, rw, asa, pw, br} = '0;
        {asb, pcs, aop} = '0;
        case (st)
            0:    begin asb = 2'b01; irw = 1'b1; pw = 1'b1; end
            1:    asb = 2'b11;
            2, 9: begin asa = 1'b1; asb = 2'b10; end
            3:    iord = 1'b1;
            4:    begin mtr = 1'b1; rw = 1'b1; end
            5:    begin iord = 1'b1; mw = 1'b1; end
            6:    begin asa = 1'b1; aop = 2'b10; end
            7:    begin rd = 1'b1; rw = 1'b1; end
            8:    begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; br = 1'b1; end
            10:   rw = 1'b1;
            11:   begin pcs = 2'b10; pw = 1'b1; end
            default: ;
        endcase
        return {iord, mw, irw, rd, mtr, rw, asa, asb, pcs, aop, pw | (br & z), ill};
    endfunction
    task automatic build_seq(input logic [5:0] opc, output int s[$]);
        case (opc)
            6'b100011: s = '{0, 1, 2, 3, 4};
            6'b101011: s = '{0, 1, 2, 5};
            6'b000000: s = '{0, 1, 6, 7};
            6'b000100: s = '{0, 1, 8};
            6'b000010: s = '{0, 1, 11};
`ifdef MC_ADDI_EN
            6'b001000: s = '{0, 1, 9, 10};
`endif
            default:   s = '{0, 1};
        endcase
    endtask
    task automatic run_instr(input logic [5:0] opc, input int zmode, input int abort_at);
        int s[$];
        logic [14:0] obs;
        build_seq(opc, s);
        foreach (s[i]) begin
            bus.op   = (i == 1) ? opc : 6'($urandom);
            bus.zero = (zmode == 2) ? 1'($urandom) : (zmode == 1);
            @(negedge clk);
            obs = {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg, bus.regwrite,
                   bus.alusrca, bus.alusrcb, bus.pcsrc, bus.aluop, bus.pcen, bus.illegal};
            chk($sformatf("state op=%b cyc%0d", opc, i), 16'(bus.state), 16'(s[i]));
            chk($sformatf("ctrl op=%b cyc%0d st%0d", opc, i, s[i]), 16'(obs),
                16'(exp_out(s[i], bus.zero, (i == 1) && (s.size() == 2))));
            if (i == abort_at) begin
                #2 rst = 1'b1;
                #1;
                obs = {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg, bus.regwrite,
                       bus.alusrca, bus.alusrcb, bus.pcsrc, bus.aluop, bus.pcen, bus.illegal};
                chk("abort memwrite", 16'(bus.memwrite), 16'(0));
                chk("abort state", 16'(bus.state), 16'(0));
                chk("abort ctrl", 16'(obs), 16'(RST_VEC));
                @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        logic [14:0] obs;
        logic [5:0] r;
        bus.op   = 6'b101011;
        bus.zero = 1'b1;
        #12;
        obs = {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg, bus.regwrite,
               bus.alusrca, bus.alusrcb, bus.pcsrc, bus.aluop, bus.pcen, bus.illegal};
        chk("reset state", 16'(bus.state), 16'(0));
        chk("reset ctrl", 16'(obs), 16'(RST_VEC));
        @(posedge clk);
        #1 rst = 1'b0;
        run_instr(6'b100011, 2, -1);
        run_instr(6'b000000, 2, -1);
        run_instr(6'b000100, 1, -1);
        run_instr(6'b000100, 0, -1);
        run_instr(6'b101011, 2, -1);
        run_instr(6'b000010, 2, -1);
        run_instr(6'b111111, 2, -1);
        run_instr(6'b001000, 2, -1);
        run_instr(6'b101011, 2, 3);
        run_instr(6'b100011, 2, -1);
        for (int n = 0; n < 300; n++) begin
            int k = $urandom_range(0, 6);
            if (k < 6) r = ops[k];
            else begin
                r = 6'($urandom);
                while (r inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})
                    r = 6'($urandom);
            end
            run_instr(r, 2, -1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
